// File: rtl/vx_ahb_mem_responder.sv
// vx_ahb_mem_responder: AHB-Lite subordinate backed by an internal word memory.
// Single-beat transfers, programmable wait states on OKAY data phases and a
// two-cycle ERROR response for out-of-range, bad-size or misaligned transfers.
// Optional feature macro: VX_AHB_SUBWORD_EN (byte/halfword writes with lane
// enables). When undefined only aligned word transfers are legal.
module vx_ahb_mem_responder #(
  parameter int                        AHB_DATA_WIDTH = 32,
  parameter int                        AHB_ADDR_WIDTH = 32,
  parameter int                        MEM_WORDS      = 1024,
  parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        WAIT_STATES    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      HSEL,
  input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic                      HWRITE,
  input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [AHB_DATA_WIDTH-1:0] HRDATA
);

  localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int NBYTES = AHB_DATA_WIDTH / 8;
  localparam logic [AHB_ADDR_WIDTH-1:0] MEM_BYTES = AHB_ADDR_WIDTH'(MEM_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [NBYTES-1:0]   be_q, be_d;

  logic [AHB_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [AHB_ADDR_WIDTH-1:0] offset;
  logic                      accept;
  logic                      in_range;
  logic                      size_ok;
  logic [NBYTES-1:0]         addr_be;
  logic                      done;
  logic                      take;
  logic                      wr_en;

  // Address-phase decode: range, size/alignment legality and byte lanes.
  always_comb begin
    offset   = HADDR - BASE_ADDR;
    accept   = HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11);
    in_range = (offset < MEM_BYTES);
    size_ok  = 1'b0;
    addr_be  = '1;
`ifdef VX_AHB_SUBWORD_EN
    case (HSIZE)
      3'b000: begin
        size_ok = 1'b1;
        addr_be = NBYTES'(1) << HADDR[1:0];
      end
      3'b001: begin
        size_ok = (HADDR[0] == 1'b0);
        addr_be = HADDR[1] ? NBYTES'(4'b1100) : NBYTES'(4'b0011);
      end
      3'b010:  size_ok = (HADDR[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
`else
    size_ok = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00);
`endif
  end

  // A data phase completes when its wait counter has drained.
  always_comb begin
    done      = (state_q == S_DATA) && (wcnt_q == 4'd0);
    wr_en     = done && wr_q;
    HREADYOUT = (state_q == S_IDLE) || (state_q == S_ERR2) || done;
    HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    HRDATA    = (done && !wr_q) ? mem[idx_q] : '0;
  end

  // Next-state: a new address phase is only taken where the bus is ready.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    be_d    = be_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: take = 1'b1;
      S_DATA: begin
        if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
        take = (wcnt_q == 4'd0);
      end
      S_ERR1: state_d = S_ERR2;
      S_ERR2: take = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      if (accept && in_range && size_ok) begin
        state_d = S_DATA;
        wcnt_d  = 4'(WAIT_STATES);
        idx_d   = offset[IDX_W+1:2];
        wr_d    = HWRITE;
        be_d    = addr_be;
      end else if (accept) begin
        state_d = S_ERR1;
        wr_d    = 1'b0;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Control state; reset aborts any data phase so a pending write never commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
    end
  end

  // Memory array (not reset): write commits at the end of the completing data phase.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vx_ahb_mem_responder.sv
// Bench for vx_ahb_mem_responder: two instances (0 and 3 wait states) driven
// by directed transfers; a transaction-level model predicts every cycle.
module tb_vx_ahb_mem_responder;

  localparam int MW = 1024;

  logic clk, reset;
  logic [1:0]        hsel, hwrite;
  logic [1:0][1:0]   htrans;
  logic [1:0][2:0]   hsize;
  logic [1:0][31:0]  haddr, hwdata;
  logic rdy0, rdy1, resp0, resp1;
  logic [31:0] rd0, rd1;
  logic [1:0]        ordy, oresp;
  logic [1:0][31:0]  ordata;
  assign ordy   = {rdy1, rdy0};
  assign oresp  = {resp1, resp0};
  assign ordata = {rd1, rd0};

  vx_ahb_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HSIZE(hsize[0]), .HWRITE(hwrite[0]), .HWDATA(hwdata[0]), .HREADY(rdy0),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));

  vx_ahb_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u1 (
    .clk(clk), .reset(reset), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HSIZE(hsize[1]), .HWRITE(hwrite[1]), .HWDATA(hwdata[1]), .HREADY(rdy1),
    .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rd1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Expected behaviour of one cycle of a unit's bus outputs.
  typedef struct {
    logic        rdy;
    logic        resp;
    logic        rd;
    logic        wr;
    int          idx;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] mdl [2][MW];

  function automatic logic legal(logic [31:0] a, logic [2:0] s);
    logic [31:0] off;
    off = a;  // base address is 0
    if (off >= MW * 4) return 1'b0;
`ifdef VX_AHB_SUBWORD_EN
    case (s)
      3'b000:  return 1'b1;
      3'b001:  return a[0] == 1'b0;
      3'b010:  return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
`else
    return (s == 3'b010) && (a[1:0] == 2'b00);
`endif
  endfunction

  function automatic logic [3:0] lanes(logic [31:0] a, logic [2:0] s);
`ifdef VX_AHB_SUBWORD_EN
    if (s == 3'b000) return 4'b0001 << a[1:0];
    if (s == 3'b001) return a[1] ? 4'b1100 : 4'b0011;
`endif
    return 4'b1111;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Compare process: every cycle, each unit's outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] erd, m;
    if (!reset) begin
      q0.delete();
      q1.delete();
    end else begin
      for (int u = 0; u < 2; u++) begin
        e = '{rdy: 1'b1, resp: 1'b0, rd: 1'b0, wr: 1'b0, idx: 0, wdata: 32'h0, be: 4'h0};
        if (u == 0 && q0.size() > 0) e = q0.pop_front();
        else if (u == 1 && q1.size() > 0) e = q1.pop_front();
        erd = e.rd ? mdl[u][e.idx] : 32'h0;
        n_vec++;
        if (ordy[u] !== e.rdy || oresp[u] !== e.resp || ordata[u] !== erd) begin
          n_err++;
          $display("FAIL u%0d cyc%0d rdy/resp/rdata: got %b/%b/%h want %b/%b/%h",
                   u, cyc, ordy[u], oresp[u], ordata[u], e.rdy, e.resp, erd);
        end
        if (e.wr) begin
          for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{e.be[b]}};
          mdl[u][e.idx] = (mdl[u][e.idx] & ~m) | (e.wdata & m);
        end
      end
    end
  end

  task automatic push(int u, exp_t e);
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Present one address phase (entered just after a rising edge), hold it
  // until accepted, then supply write data and queue the data-phase prediction.
  task automatic issue(int u, logic [31:0] a, logic [2:0] s, logic w, logic [31:0] d);
    logic r;
    int   n;
    int   ws;
    exp_t e;
    hsel[u] = 1'b1; htrans[u] = 2'b10; haddr[u] = a; hsize[u] = s; hwrite[u] = w;
    n = 0;
    do begin
      @(negedge clk); r = ordy[u];
      @(posedge clk); #1;
      n++;
    end while (!r && n < 64);
    if (!r) chk("accept_timeout", 32'h0, 32'h1);
    hwdata[u] = d;
    hsel[u] = 1'b0; htrans[u] = 2'b00;
    ws = (u == 0) ? 0 : 3;
    e = '{rdy: 1'b0, resp: 1'b0, rd: 1'b0, wr: 1'b0, idx: 0, wdata: 32'h0, be: 4'h0};
    if (legal(a, s)) begin
      repeat (ws) push(u, e);
      e.rdy = 1'b1; e.rd = !w; e.wr = w; e.idx = int'(a >> 2); e.wdata = d; e.be = lanes(a, s);
      push(u, e);
    end else begin
      e.resp = 1'b1;
      push(u, e);
      e.rdy = 1'b1;
      push(u, e);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Wait for the current data phase to complete; report read data and stall count.
  task automatic wait_done(int u, output logic [31:0] d, output int lows);
    d = 'x; lows = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ordy[u]) begin d = ordata[u]; break; end
      lows++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int lows, c0;
    reset = 1'b0;
    hsel = '0; htrans = '0; haddr = '0; hsize = '0; hwrite = '0; hwdata = '0;
    #12;
    chk("reset_rdy0", 32'(rdy0), 32'h1);
    chk("reset_resp0", 32'(resp0), 32'h0);
    chk("reset_rdata0", rd0, 32'h0);
    chk("reset_rdy1", 32'(rdy1), 32'h1);
    chk("reset_resp1", 32'(resp1), 32'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Write then immediate read, zero wait states.
    issue(0, 32'h40, 3'b010, 1'b1, 32'hDEADBEEF);
    issue(0, 32'h40, 3'b010, 1'b0, 32'h0);
    wait_done(0, d, lows);
    chk("wr_rd_data", d, 32'hDEADBEEF);
    chk("wr_rd_stalls", 32'(lows), 32'h0);

    // Three wait states on a read of word 0.
    issue(1, 32'h0, 3'b010, 1'b1, 32'h13579BDF);
    issue(1, 32'h0, 3'b010, 1'b0, 32'h0);
    wait_done(1, d, lows);
    chk("ws3_data", d, 32'h13579BDF);
    chk("ws3_stalls", 32'(lows), 32'h3);

    // Out-of-range read: two-cycle error.
    issue(0, 32'h1000, 3'b010, 1'b0, 32'h0);
    @(negedge clk);
    chk("err1_resp", 32'(resp0), 32'h1);
    chk("err1_rdy", 32'(rdy0), 32'h0);
    @(negedge clk);
    chk("err2_resp", 32'(resp0), 32'h1);
    chk("err2_rdy", 32'(rdy0), 32'h1);
    @(posedge clk); #1;
    // Out-of-range and misaligned writes must not touch memory.
    issue(0, 32'h1040, 3'b010, 1'b1, 32'hBAD0BAD0);
    issue(0, 32'h42, 3'b010, 1'b1, 32'hBAD1BAD1);
    issue(0, 32'h40, 3'b010, 1'b0, 32'h0);
    wait_done(0, d, lows);
    chk("err_no_write", d, 32'hDEADBEEF);

    // Not selected, and BUSY: no transfer.
    hsel[0] = 1'b0; htrans[0] = 2'b10; haddr[0] = 32'h40; hwrite[0] = 1'b1; hsize[0] = 3'b010;
    idle(3);
    hsel[0] = 1'b1; htrans[0] = 2'b01;
    idle(3);
    hsel[0] = 1'b0; htrans[0] = 2'b00;
    idle(2);

    // Sixteen writes then sixteen reads, one per cycle.
    c0 = cyc;
    for (int i = 0; i < 16; i++) issue(0, 32'h100 + 32'(4 * i), 3'b010, 1'b1, 32'hC0DE0000 + 32'(i));
    for (int i = 0; i < 16; i++) issue(0, 32'h100 + 32'(4 * i), 3'b010, 1'b0, 32'h0);
    chk("b2b_cycles", 32'(cyc - c0), 32'd32);
    idle(3);

    // Byte write into a cleared word; halfword misaligned is always an error.
    issue(0, 32'h40, 3'b010, 1'b1, 32'h0);
    issue(0, 32'h42, 3'b000, 1'b1, 32'h00A50000);
    issue(0, 32'h41, 3'b001, 1'b1, 32'hFFFFFFFF);
    issue(0, 32'h40, 3'b010, 1'b0, 32'h0);
    wait_done(0, d, lows);
`ifdef VX_AHB_SUBWORD_EN
    chk("byte_write", d, 32'h00A50000);
`else
    chk("byte_write", d, 32'h00000000);
`endif

    // Reset during a write wait state discards the write.
    issue(1, 32'h200, 3'b010, 1'b1, 32'h11111111);
    idle(6);
    issue(1, 32'h200, 3'b010, 1'b1, 32'h22222222);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_rdy", 32'(rdy1), 32'h1);
    chk("rst_mid_resp", 32'(resp1), 32'h0);
    chk("rst_mid_rdata", rd1, 32'h0);
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    issue(1, 32'h200, 3'b010, 1'b0, 32'h0);
    wait_done(1, d, lows);
    chk("rst_old_word", d, 32'h11111111);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vx_ahb_mem_responder.md
# vx_ahb_mem_responder

AHB-Lite subordinate that terminates the Vortex-side AHB initiator on the bus and serves its single-beat word transfers from an internal word-addressed memory. It decodes address phases, inserts a programmable number of wait states, performs the data phase, and returns a two-cycle ERROR response for illegal transfers. It is the bus-side counterpart used in simulation and FPGA bring-up, so the initiator can be exercised without external memory.

## Interface
- AHB_DATA_WIDTH, 32: data bus width; only 32 is supported.
- AHB_ADDR_WIDTH, 32: address bus width.
- MEM_WORDS, 1024: memory depth in 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be MEM_WORDS*4 aligned.
- WAIT_STATES, 0: wait cycles per OKAY data phase, range 0..15.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- HSEL  in  1  subordinate select.
- HADDR  in  AHB_ADDR_WIDTH  byte address (address phase).
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  1 = write.
- HWDATA  in  AHB_DATA_WIDTH  write data (data phase).
- HREADY  in  1  bus-level ready; equals HREADYOUT in a single-subordinate system.
- HREADYOUT  out  1  this subordinate's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  AHB_DATA_WIDTH  read data (data phase).

## Operation
- Address phase accepted when HSEL && HTRANS[1] && HREADY; latch word index, HWRITE, HSIZE, and HADDR[1:0].
- HTRANS IDLE/BUSY, or HSEL=0: no transfer; no state change beyond completing the current data phase.
- A transfer is illegal if it is out of range ((HADDR - BASE_ADDR) >= MEM_WORDS*4, unsigned), has an unsupported HSIZE, or is misaligned for its size.
- States: IDLE, DATA, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0. On an accepted legal transfer: DATA with wait counter = WAIT_STATES. On an accepted illegal transfer: ERR1.
- DATA: HREADYOUT = (wait counter == 0); the counter decrements while nonzero. In the completing cycle (HREADYOUT=1):
  - Write: store HWDATA into memory at the clock edge.
  - Read: HRDATA = mem[latched index].
  - In the same cycle, accept a new address phase if presented (to DATA or ERR1); otherwise go to IDLE.
- ERR1: HRESP=1, HREADYOUT=0. Next state is ERR2. Errors never insert wait states.
- ERR2: HRESP=1, HREADYOUT=1. Accept a new address phase if presented; otherwise go to IDLE. An error transfer never writes memory.
- HRDATA is 0 outside a completing read data phase.
- Back-to-back write then read to the same word returns the newly written data, because the write commits at the end of the earlier data phase.

## Timing
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0. Memory contents are not reset.
- Reset asserted mid-transfer aborts the transfer; any pending write is discarded.
- OKAY latency: address phase in cycle N; data phase completes in cycle N+1+WAIT_STATES.
- ERROR: address phase in cycle N; ERR1 in cycle N+1; ERR2 in cycle N+2.
- Full pipelining: with WAIT_STATES=0, one transfer completes every cycle.
- Address-phase inputs are ignored while HREADY=0.

## Configuration
- VX_AHB_SUBWORD_EN defined:
  - HSIZE 000 (byte), 001 (halfword), and 010 (word) are legal. Halfword requires HADDR[0]=0; word requires HADDR[1:0]=0.
  - Writes update only the byte lanes selected by HSIZE and HADDR[1:0].
  - Reads always return the full word.
- Not defined: only HSIZE 010 with HADDR[1:0]=0 is legal; every other size gets an ERROR response.

## Test plan
- WAIT_STATES=0: write 32'hDEADBEEF to 0x40, then immediate read of 0x40 -> HRDATA=32'hDEADBEEF in cycle N+2 of the pair, HRESP=0, HREADYOUT never low.
- WAIT_STATES=3: read of 0x0 -> HREADYOUT low for exactly 3 cycles, then high with the stored data.
- Out-of-range read at BASE_ADDR+MEM_WORDS*4 -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then OKAY; memory unchanged.
- Sixteen back-to-back NONSEQ word writes at stride 4 from 0x100, then sixteen reads -> data matches, one completion per cycle.
- Reset deasserted→asserted during a write wait state -> outputs return to reset values; a later read shows the old word.
- With VX_AHB_SUBWORD_EN: byte write 8'hA5 to 0x42 over 32'h0 -> word reads 32'h00A50000. Without the macro, the same transfer gets ERROR.
